ysyx_24100005_core_seq: RTL and testbench

YSYX_24100005_CORE_SEQ -- requirements
Module: ysyx_24100005_core_seq

---
 rtl/ysyx_24100005_core_seq.sv | 126 ++++++++++++
 tb/tb_ysyx_24100005_core_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_core_seq.sv
// Multi-cycle instruction sequencer: FETCH -> WAIT -> EXEC -> COMMIT, with HALT on ebreak or fault.
// Optional fetch watchdog enabled by defining YSYX_24100005_FETCH_TIMEOUT_EN.
module ysyx_24100005_core_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_resp_valid,
    output logic        ifu_resp_ready,
    input  logic [31:0] ifu_resp_inst,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic [31:0] dnpc,
    input  logic        dec_rf_wen,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state_dbg
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both
    // high; a raised valid holds with stable payload until that edge.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT   = 3'd1,
        EXEC   = 3'd2,
        COMMIT = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        set_err;
    logic        is_ebreak;
    logic        timed_out;
    logic [31:0] npc_q;

    assign is_ebreak = (inst[6:0] == 7'b1110011);

    if (TIMEOUT < 1) begin : g_timeout_range
    end

`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
    logic [31:0] wcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= 32'd0;
        end else if (state == FETCH && ifu_req_ready) begin
            wcnt <= 32'd0;
        end else if (state == WAIT) begin
            wcnt <= wcnt + 32'd1;
        end
    end

    // The response is checked before the timeout, so a reply on the last cycle wins.
    assign timed_out = (state == WAIT) && !ifu_resp_valid && (wcnt == 32'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n = state;
        set_err = 1'b0;
        case (state)
            FETCH:  if (ifu_req_ready) state_n = WAIT;
            WAIT: begin
                if (ifu_resp_valid) begin
                    state_n = EXEC;
                end else if (timed_out) begin
                    state_n = HALT;
                    set_err = 1'b1;
                end
            end
            EXEC: begin
                if (is_ebreak) begin
                    state_n = HALT;
                end else if (dnpc[1:0] != 2'b00) begin
                    state_n = HALT;
                    set_err = 1'b1;
                end else begin
                    state_n = COMMIT;
                end
            end
            COMMIT: state_n = FETCH;
            HALT:   state_n = HALT;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            inst    <= 32'h0000_0013;
            npc_q   <= RESET_PC;
            retired <= 32'd0;
            err     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == WAIT && ifu_resp_valid) inst <= ifu_resp_inst;
            if (state == EXEC) npc_q <= dnpc;
            if (state == COMMIT) begin
                pc      <= npc_q;
                retired <= retired + 32'd1;
            end
            if (set_err) err <= 1'b1;
        end
    end

    // Request valid is held off while reset is asserted, even though state already reads FETCH.
    assign ifu_req_valid  = rst && (state == FETCH);
    assign ifu_req_addr   = pc;
    assign ifu_resp_ready = (state == WAIT);
    assign inst_valid     = (state == EXEC);
    assign rf_wen         = (state == COMMIT) && dec_rf_wen;
    assign halted         = (state == HALT);
    assign state_dbg      = state;

endmodule

// File: tb/tb_ysyx_24100005_core_seq.sv
// Scoreboard bench for ysyx_24100005_core_seq: driver tasks issue fetch transactions,
// a negedge monitor pops expected instructions, commits and write strobes.
module tb_ysyx_24100005_core_seq;

    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_resp_inst;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] dnpc;
    logic        dec_rf_wen;
    logic        rf_wen;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic        err;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_inst_q[$];
    logic [63:0] exp_commit_q[$];
    logic        exp_wen_q[$];

    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] prev_ret;

    ysyx_24100005_core_seq #(.RESET_PC(RPC), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_inst(ifu_resp_inst),
        .inst(inst), .inst_valid(inst_valid), .dnpc(dnpc), .dec_rf_wen(dec_rf_wen),
        .rf_wen(rf_wen), .pc(pc), .retired(retired), .halted(halted), .err(err),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (inst_valid) begin
                chk("inst_valid_vs_rf_wen", {31'd0, rf_wen}, 32'd0);
                if (exp_inst_q.size() == 0) chk("unexpected_exec", 32'd1, 32'd0);
                else chk("exec_inst", inst, exp_inst_q.pop_front());
            end
            if (state_dbg == 3'd3) begin
                if (exp_wen_q.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
                else chk("commit_rf_wen", {31'd0, rf_wen}, {31'd0, exp_wen_q.pop_front()});
            end else if (rf_wen) begin
                chk("rf_wen_outside_commit", {31'd0, rf_wen}, 32'd0);
            end
            if (retired != prev_ret) begin
                if (exp_commit_q.size() == 0) chk("unexpected_retire", retired, prev_ret);
                else begin
                    logic [63:0] e;
                    e = exp_commit_q.pop_front();
                    chk("commit_pc", pc, e[63:32]);
                    chk("commit_retired", retired, e[31:0]);
                end
            end
        end
        prev_ret = retired;
    end

    // drivers
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        #2;
        chk("rst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
        chk("rst_pc", pc, RPC);
        chk("rst_inst", inst, ADDI);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halted_err", {30'd0, halted, err}, 32'd0);
        chk("rst_strobes", {29'd0, ifu_resp_ready, inst_valid, rf_wen}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_req_valid", {31'd0, ifu_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("release_req_valid", {31'd0, ifu_req_valid}, 32'd1);
        exp_pc = RPC;
        exp_ret = 32'd0;
    endtask

    // kind: 0 = commits, 1 = clean halt (ebreak), 2 = fault halt
    task automatic txn(input logic [31:0] iw, input int req_delay, input int resp_delay,
                       input logic [31:0] npc, input logic wen, input int kind);
        int n;
        int t0;
        logic [31:0] addr0;
        n = 0;
        while (!ifu_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid_seen", {31'd0, ifu_req_valid}, 32'd1);
        addr0 = ifu_req_addr;
        chk("req_addr", addr0, exp_pc);
        ifu_req_ready = 1'b0;
        for (int i = 0; i < req_delay; i++) begin
            @(negedge clk);
            chk("req_valid_held", {31'd0, ifu_req_valid}, 32'd1);
            chk("req_addr_stable", ifu_req_addr, addr0);
        end
        ifu_req_ready = 1'b1;
        t0 = cyc;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        chk("wait_resp_ready", {30'd0, ifu_resp_ready, ifu_req_valid}, 32'd2);
        repeat (resp_delay) @(negedge clk);
        chk("wait_still_pending", {31'd0, ifu_resp_ready}, 32'd1);
        ifu_resp_valid = 1'b1;
        ifu_resp_inst  = iw;
        dnpc           = npc;
        dec_rf_wen     = wen;
        exp_inst_q.push_back(iw);
        if (kind == 0) begin
            exp_wen_q.push_back(wen);
            exp_commit_q.push_back({npc, exp_ret + 32'd1});
        end
        @(negedge clk);
        ifu_resp_valid = 1'b0;
        @(negedge clk);
        if (kind == 0) begin
            @(negedge clk);
            exp_pc  = npc;
            exp_ret = exp_ret + 32'd1;
            chk("latency", 32'(cyc - t0), 32'(4 + resp_delay));
            chk("pc_after_commit", pc, exp_pc);
            chk("retired_after_commit", retired, exp_ret);
        end else begin
            chk("halted", {31'd0, halted}, 32'd1);
            chk("halt_err", {31'd0, err}, (kind == 2) ? 32'd1 : 32'd0);
            chk("halt_pc_frozen", pc, exp_pc);
            chk("halt_retired_frozen", retired, exp_ret);
        end
    endtask

    task automatic check_halt_frozen(input logic [31:0] exp_inst, input logic exp_err);
        for (int i = 0; i < 3; i++) begin
            ifu_resp_valid = 1'b1;
            ifu_resp_inst  = ADDI ^ 32'(i + 1);
            ifu_req_ready  = 1'b1;
            @(negedge clk);
        end
        ifu_resp_valid = 1'b0;
        ifu_req_ready  = 1'b0;
        chk("halt_inst_unchanged", inst, exp_inst);
        chk("halt_strobes", {28'd0, ifu_req_valid, ifu_resp_ready, inst_valid, rf_wen}, 32'd0);
        chk("halt_state", {30'd0, halted, err}, {30'd0, 1'b1, exp_err});
        chk("halt_pc_still", pc, exp_pc);
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_inst = 32'd0;
        dnpc = 32'd0;
        dec_rf_wen = 1'b0;
        exp_pc = RPC;
        exp_ret = 32'd0;
        prev_ret = 32'd0;

        do_reset();
        txn(ADDI, 0, 0, RPC + 32'd4, 1'b1, 0);
        txn(ADDI, 3, 0, 32'h8000_0008, 1'b0, 0);
        txn(32'h0050_0093, 1, 2, 32'h8000_1000, 1'b1, 0);
        txn(32'h1234_5678, 0, 1, 32'h8000_0006, 1'b1, 2);
        check_halt_frozen(32'h1234_5678, 1'b1);

        // reset while a fetch is outstanding, then a stale response after release
        do_reset();
        txn(32'h00a0_0113, 0, 0, RPC + 32'd4, 1'b1, 0);
        do_reset();
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        chk("midwait_in_wait", {31'd0, ifu_resp_ready}, 32'd1);
        rst = 1'b0;
        #2;
        chk("midwait_rst_pc", pc, RPC);
        chk("midwait_rst_resp_ready", {31'd0, ifu_resp_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ifu_resp_valid = 1'b1;
        ifu_resp_inst  = EBRK;
        @(negedge clk);
        ifu_resp_valid = 1'b0;
        @(negedge clk);
        chk("stale_resp_inst", inst, ADDI);
        chk("stale_resp_state", {29'd0, halted, inst_valid, ifu_req_valid}, 32'd1);
        txn(ADDI, 2, 0, RPC + 32'd4, 1'b0, 0);

        txn(EBRK, 0, 0, 32'h8000_0008, 1'b1, 1);
        check_halt_frozen(EBRK, 1'b0);

        do_reset();
`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
        txn(ADDI, 0, 15, RPC + 32'd4, 1'b1, 0);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        repeat (15) @(negedge clk);
        chk("timeout_not_yet", {30'd0, halted, ifu_resp_ready}, 32'd1);
        @(negedge clk);
        chk("timeout_halt", {30'd0, halted, err}, 32'd3);
        chk("timeout_pc", pc, exp_pc);
`else
        txn(ADDI, 0, 40, RPC + 32'd4, 1'b1, 0);
`endif

        repeat (3) @(negedge clk);
        chk("inst_q_empty", 32'(exp_inst_q.size()), 32'd0);
        chk("commit_q_empty", 32'(exp_commit_q.size()), 32'd0);
        chk("wen_q_empty", 32'(exp_wen_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
